// File: rtl/gpu_fb_pkg.sv
// Shared types and screen constants for the framebuffer write path.
package gpu_fb_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int CHANNEL_BITS  = 8;
    localparam int COLOR_BITS    = 3 * CHANNEL_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } fb_state_t;

    typedef enum logic {
        LINE = 1'b0,
        FILL = 1'b1
    } req_id_t;

endpackage

// File: rtl/gpu_fb_addr_calc.sv
// Pixel (x,y) to back-buffer linear address, plus off-screen detection.
// The row multiply is a constant shift-add (640 = 512 + 128).
module gpu_fb_addr_calc #(
    parameter int WIDTH_BITS    = 10,
    parameter int HEIGHT_BITS   = 9,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FB_ADDR_BITS  = 20
) (
    input  logic [WIDTH_BITS-1:0]   x,
    input  logic [HEIGHT_BITS-1:0]  y,
    input  logic                    front_sel,
    output logic [FB_ADDR_BITS-1:0] addr,
    output logic                    clipped
);

    localparam int                   LIN_BITS = FB_ADDR_BITS - 1;
    localparam logic [31:0]          STRIDE   = 32'(SCREEN_WIDTH);
    localparam logic [WIDTH_BITS:0]  X_LIMIT  = (WIDTH_BITS + 1)'(SCREEN_WIDTH);
    localparam logic [HEIGHT_BITS:0] Y_LIMIT  = (HEIGHT_BITS + 1)'(SCREEN_HEIGHT);

    logic [LIN_BITS-1:0] x_ext_s;
    logic [LIN_BITS-1:0] y_ext_s;
    logic [LIN_BITS-1:0] row_base_s;

    assign x_ext_s = LIN_BITS'(x);
    assign y_ext_s = LIN_BITS'(y);

    // Row base = y * stride, summing one shifted copy of y per set stride bit
    always_comb begin
        row_base_s = '0;
        for (int i = 0; i < LIN_BITS; i++) begin
            row_base_s = row_base_s + (STRIDE[i] ? (y_ext_s << i) : {LIN_BITS{1'b0}});
        end
    end

    // Writes always land in the buffer not being displayed
    always_comb begin
        addr    = {~front_sel, row_base_s + x_ext_s};
        clipped = ({1'b0, x} >= X_LIMIT) || ({1'b0, y} >= Y_LIMIT);
    end

endmodule

// File: rtl/gpu_fb_write_arbiter.sv
// Framebuffer write arbiter: round-robin between line and fill engines,
// clipping, single-entry output stage held until SRAM ack, and
// drain-then-flip double-buffer swap sequencing.
module gpu_fb_write_arbiter #(
    parameter int WIDTH_BITS    = 10,
    parameter int HEIGHT_BITS   = 9,
    parameter int CHANNEL_BITS  = gpu_fb_pkg::CHANNEL_BITS,
    parameter int SCREEN_WIDTH  = gpu_fb_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = gpu_fb_pkg::SCREEN_HEIGHT,
    parameter int FB_ADDR_BITS  = 20
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      line_valid_i,
    output logic                      line_ready_o,
    input  logic [WIDTH_BITS-1:0]     line_x_i,
    input  logic [HEIGHT_BITS-1:0]    line_y_i,
    input  logic [3*CHANNEL_BITS-1:0] line_color_i,
    input  logic                      fill_valid_i,
    output logic                      fill_ready_o,
    input  logic [WIDTH_BITS-1:0]     fill_x_i,
    input  logic [HEIGHT_BITS-1:0]    fill_y_i,
    input  logic [3*CHANNEL_BITS-1:0] fill_color_i,
    input  logic                      swap_req_i,
    output logic                      swap_done_o,
    output logic                      front_sel_o,
    output logic                      mem_req_o,
    output logic [FB_ADDR_BITS-1:0]   mem_addr_o,
    output logic [3*CHANNEL_BITS-1:0] mem_data_o,
    input  logic                      mem_ack_i,
    output logic [15:0]               clip_count_o,
    output logic                      idle_o
);

    import gpu_fb_pkg::*;

    localparam int COLOR_W = 3 * CHANNEL_BITS;

    fb_state_t             state_r;
    fb_state_t             next_state_s;
    req_id_t               last_grant_r;
    logic                  swap_pending_r;
    logic                  front_sel_r;
    logic [15:0]           clip_count_r;
    logic [FB_ADDR_BITS-1:0] mem_addr_r;
    logic [COLOR_W-1:0]    mem_data_r;

    logic                  grant_line_s;
    logic                  grant_fill_s;
    logic                  can_accept_s;
    logic                  hs_s;
    logic                  write_s;
    logic [WIDTH_BITS-1:0] sel_x_s;
    logic [HEIGHT_BITS-1:0] sel_y_s;
    logic [COLOR_W-1:0]    sel_color_s;
    logic [FB_ADDR_BITS-1:0] calc_addr_s;
    logic                  calc_clipped_s;

    // A new pixel fits only when the output stage is empty or emptying this cycle
    assign can_accept_s = !swap_pending_r &&
                          ((state_r == IDLE) || ((state_r == BUSY) && mem_ack_i));

    // Round-robin grant: on a tie the requester that was not served last wins
    always_comb begin
        grant_line_s = 1'b0;
        grant_fill_s = 1'b0;
        if (line_valid_i && fill_valid_i) begin
            if (last_grant_r == FILL) begin
                grant_line_s = 1'b1;
            end else begin
                grant_fill_s = 1'b1;
            end
        end else begin
            grant_line_s = line_valid_i;
            grant_fill_s = fill_valid_i;
        end
    end

    assign line_ready_o = can_accept_s && grant_line_s;
    assign fill_ready_o = can_accept_s && grant_fill_s;
    assign hs_s         = line_ready_o || fill_ready_o;
    assign write_s      = hs_s && !calc_clipped_s;

    // Select the granted requester's pixel for address calculation and capture
    always_comb begin
        if (grant_fill_s) begin
            sel_x_s     = fill_x_i;
            sel_y_s     = fill_y_i;
            sel_color_s = fill_color_i;
        end else begin
            sel_x_s     = line_x_i;
            sel_y_s     = line_y_i;
            sel_color_s = line_color_i;
        end
    end

    gpu_fb_addr_calc #(
        .WIDTH_BITS    (WIDTH_BITS),
        .HEIGHT_BITS   (HEIGHT_BITS),
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .FB_ADDR_BITS  (FB_ADDR_BITS)
    ) u_addr_calc (
        .x         (sel_x_s),
        .y         (sel_y_s),
        .front_sel (front_sel_r),
        .addr      (calc_addr_s),
        .clipped   (calc_clipped_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state: a pending swap always drains the output stage before flipping
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (swap_pending_r) begin
                    next_state_s = SWAP;
                end else if (write_s) begin
                    next_state_s = BUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                if (!mem_ack_i) begin
                    if (swap_pending_r) begin
                        next_state_s = DRAIN;
                    end else begin
                        next_state_s = BUSY;
                    end
                end else if (swap_pending_r) begin
                    // Last write acked in the same cycle: nothing left to drain
                    next_state_s = SWAP;
                end else if (write_s) begin
                    next_state_s = BUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    next_state_s = SWAP;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            SWAP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the state register
    always_comb begin
        mem_req_o   = 1'b0;
        swap_done_o = 1'b0;
        case (state_r)
            IDLE:    begin mem_req_o = 1'b0; swap_done_o = 1'b0; end
            BUSY:    begin mem_req_o = 1'b1; swap_done_o = 1'b0; end
            DRAIN:   begin mem_req_o = 1'b1; swap_done_o = 1'b0; end
            SWAP:    begin mem_req_o = 1'b0; swap_done_o = 1'b1; end
            default: begin mem_req_o = 1'b0; swap_done_o = 1'b0; end
        endcase
        idle_o = (state_r == IDLE) && !swap_pending_r;
    end

    // Swap request latch: repeated pulses merge; a pulse during SWAP starts a new one
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            swap_pending_r <= 1'b0;
        end else begin
            swap_pending_r <= swap_req_i || (swap_pending_r && (state_r != SWAP));
        end
    end

    // Front buffer flips on entry to SWAP so it reads back flipped during the done pulse
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            front_sel_r <= 1'b0;
        end else if (next_state_s == SWAP) begin
            front_sel_r <= ~front_sel_r;
        end else begin
            front_sel_r <= front_sel_r;
        end
    end

    // Round-robin history: remember who was served, clipped or not
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_grant_r <= FILL;
        end else if (hs_s) begin
            last_grant_r <= grant_fill_s ? FILL : LINE;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Output stage: captured only for on-screen pixels, held until the next capture
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_addr_r <= '0;
            mem_data_r <= '0;
        end else if (write_s) begin
            mem_addr_r <= calc_addr_s;
            mem_data_r <= sel_color_s;
        end else begin
            mem_addr_r <= mem_addr_r;
            mem_data_r <= mem_data_r;
        end
    end

    // Saturating count of accepted-but-clipped pixels
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clip_count_r <= 16'd0;
        end else if (hs_s && calc_clipped_s && (clip_count_r != 16'hFFFF)) begin
            clip_count_r <= clip_count_r + 16'd1;
        end else begin
            clip_count_r <= clip_count_r;
        end
    end

    assign front_sel_o  = front_sel_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_data_o   = mem_data_r;
    assign clip_count_o = clip_count_r;

endmodule

// File: tb/tb_gpu_fb_write_arbiter.sv
// Directed bench for gpu_fb_write_arbiter with hand-computed expectations.
module tb_gpu_fb_write_arbiter;

    logic        clk;
    logic        n_rst;
    logic        line_valid_i;
    logic        line_ready_o;
    logic [9:0]  line_x_i;
    logic [8:0]  line_y_i;
    logic [23:0] line_color_i;
    logic        fill_valid_i;
    logic        fill_ready_o;
    logic [9:0]  fill_x_i;
    logic [8:0]  fill_y_i;
    logic [23:0] fill_color_i;
    logic        swap_req_i;
    logic        swap_done_o;
    logic        front_sel_o;
    logic        mem_req_o;
    logic [19:0] mem_addr_o;
    logic [23:0] mem_data_o;
    logic        mem_ack_i;
    logic [15:0] clip_count_o;
    logic        idle_o;

    int n_checks;
    int n_fail;

    gpu_fb_write_arbiter dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .line_valid_i (line_valid_i),
        .line_ready_o (line_ready_o),
        .line_x_i     (line_x_i),
        .line_y_i     (line_y_i),
        .line_color_i (line_color_i),
        .fill_valid_i (fill_valid_i),
        .fill_ready_o (fill_ready_o),
        .fill_x_i     (fill_x_i),
        .fill_y_i     (fill_y_i),
        .fill_color_i (fill_color_i),
        .swap_req_i   (swap_req_i),
        .swap_done_o  (swap_done_o),
        .front_sel_o  (front_sel_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_ack_i    (mem_ack_i),
        .clip_count_o (clip_count_o),
        .idle_o       (idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b want 0", mem_req_o); end
        n_checks++; if (front_sel_o !== 1'b0) begin n_fail++; $display("FAIL reset_front_sel: got %0b want 0", front_sel_o); end
        n_checks++; if (clip_count_o !== 16'd0) begin n_fail++; $display("FAIL reset_clip_count: got %0d want 0", clip_count_o); end
        n_checks++; if (swap_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_swap_done: got %0b want 0", swap_done_o); end
        n_checks++; if ({line_ready_o, fill_ready_o} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {line_ready_o, fill_ready_o}); end
        n_rst = 1'b1;
        tick();
        n_checks++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %0b want 1", idle_o); end
    endtask

    task automatic test_back_to_back;
        logic [9:0]  lx [3];
        logic [23:0] lc [3];
        logic [9:0]  fx [3];
        logic [23:0] fc [3];
        logic [1:0]  exp_grant [5];
        logic        exp_req [5];
        logic [19:0] exp_addr [5];
        logic [23:0] exp_data [5];
        int li;
        int fi;
        lx[0] = 10'd1;   lx[1] = 10'd2;   lx[2] = 10'd0;
        lc[0] = 24'h111111; lc[1] = 24'h222222; lc[2] = 24'h000000;
        fx[0] = 10'd100; fx[1] = 10'd101; fx[2] = 10'd0;
        fc[0] = 24'hAAAAAA; fc[1] = 24'hBBBBBB; fc[2] = 24'h000000;
        // {fill_ready, line_ready}: LINE, FILL, LINE, FILL, none
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10; exp_grant[4] = 2'b00;
        exp_req[0] = 1'b0; exp_req[1] = 1'b1; exp_req[2] = 1'b1; exp_req[3] = 1'b1; exp_req[4] = 1'b1;
        exp_addr[0] = 20'h00000; exp_data[0] = 24'h000000;
        exp_addr[1] = 20'h80001; exp_data[1] = 24'h111111;
        exp_addr[2] = 20'h802E4; exp_data[2] = 24'hAAAAAA;
        exp_addr[3] = 20'h80002; exp_data[3] = 24'h222222;
        exp_addr[4] = 20'h802E5; exp_data[4] = 24'hBBBBBB;
        li = 0;
        fi = 0;
        mem_ack_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            line_valid_i = (li < 2); line_x_i = lx[li]; line_y_i = 9'd0; line_color_i = lc[li];
            fill_valid_i = (fi < 2); fill_x_i = fx[fi]; fill_y_i = 9'd1; fill_color_i = fc[fi];
            #1;
            n_checks++; if ({fill_ready_o, line_ready_o} !== exp_grant[k]) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %b want %b", k, {fill_ready_o, line_ready_o}, exp_grant[k]); end
            n_checks++; if (mem_req_o !== exp_req[k]) begin n_fail++; $display("FAIL b2b_mem_req[%0d]: got %0b want %0b", k, mem_req_o, exp_req[k]); end
            if (k > 0) begin
                n_checks++; if ((mem_addr_o !== exp_addr[k]) || (mem_data_o !== exp_data[k])) begin n_fail++; $display("FAIL b2b_write[%0d]: got %h/%h want %h/%h", k, mem_addr_o, mem_data_o, exp_addr[k], exp_data[k]); end
            end
            if (line_valid_i && line_ready_o) li++;
            if (fill_valid_i && fill_ready_o) fi++;
            tick();
        end
        line_valid_i = 1'b0;
        fill_valid_i = 1'b0;
        mem_ack_i = 1'b0;
        #1;
        n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end_req: got %0b want 0", mem_req_o); end
    endtask

    task automatic test_single_write;
        line_valid_i = 1'b1; line_x_i = 10'd10; line_y_i = 9'd2; line_color_i = 24'hFF0000;
        #1;
        n_checks++; if (line_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %0b want 1", line_ready_o); end
        tick();
        line_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if ((mem_req_o !== 1'b1) || (mem_addr_o !== 20'h8050A) || (mem_data_o !== 24'hFF0000)) begin n_fail++; $display("FAIL single_hold[%0d]: got req=%0b %h/%h want 1 8050a/ff0000", c, mem_req_o, mem_addr_o, mem_data_o); end
            if (c == 2) mem_ack_i = 1'b1;
            tick();
        end
        mem_ack_i = 1'b0;
        #1;
        n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL single_after_ack: got %0b want 0", mem_req_o); end
    endtask

    task automatic test_clip;
        fill_valid_i = 1'b1; fill_x_i = 10'd640; fill_y_i = 9'd0; fill_color_i = 24'h123456;
        #1;
        n_checks++; if (fill_ready_o !== 1'b1) begin n_fail++; $display("FAIL clip_x_ready: got %0b want 1", fill_ready_o); end
        tick();
        fill_x_i = 10'd0; fill_y_i = 9'd480;
        #1;
        n_checks++; if ((mem_req_o !== 1'b0) || (clip_count_o !== 16'd1)) begin n_fail++; $display("FAIL clip_x: got req=%0b cnt=%0d want 0/1", mem_req_o, clip_count_o); end
        tick();
        fill_x_i = 10'd639; fill_y_i = 9'd479; fill_color_i = 24'h0000FF;
        #1;
        n_checks++; if ((mem_req_o !== 1'b0) || (clip_count_o !== 16'd2)) begin n_fail++; $display("FAIL clip_y: got req=%0b cnt=%0d want 0/2", mem_req_o, clip_count_o); end
        tick();
        fill_x_i = 10'd700; fill_y_i = 9'd5;
        mem_ack_i = 1'b1;
        #1;
        n_checks++; if ((mem_req_o !== 1'b1) || (mem_addr_o !== 20'hCAFFF) || (mem_data_o !== 24'h0000FF)) begin n_fail++; $display("FAIL clip_corner: got req=%0b %h/%h want 1 cafff/0000ff", mem_req_o, mem_addr_o, mem_data_o); end
        n_checks++; if (fill_ready_o !== 1'b1) begin n_fail++; $display("FAIL clip_ack_ready: got %0b want 1", fill_ready_o); end
        tick();
        fill_valid_i = 1'b0;
        mem_ack_i = 1'b0;
        #1;
        n_checks++; if ((mem_req_o !== 1'b0) || (clip_count_o !== 16'd3)) begin n_fail++; $display("FAIL clip_over_ack: got req=%0b cnt=%0d want 0/3", mem_req_o, clip_count_o); end
    endtask

    task automatic test_swap_drain;
        line_valid_i = 1'b1; line_x_i = 10'd5; line_y_i = 9'd0; line_color_i = 24'h00FF00;
        tick();
        line_x_i = 10'd6;
        swap_req_i = 1'b1;
        #1;
        n_checks++; if ((line_ready_o !== 1'b0) || (mem_req_o !== 1'b1) || (mem_addr_o !== 20'h80005)) begin n_fail++; $display("FAIL swap_busy: got rdy=%0b req=%0b addr=%h want 0 1 80005", line_ready_o, mem_req_o, mem_addr_o); end
        tick();
        swap_req_i = 1'b0;
        #1;
        n_checks++; if ((line_ready_o !== 1'b0) || (idle_o !== 1'b0)) begin n_fail++; $display("FAIL swap_pending: got rdy=%0b idle=%0b want 0 0", line_ready_o, idle_o); end
        tick();
        mem_ack_i = 1'b1;
        #1;
        n_checks++; if ((mem_req_o !== 1'b1) || (line_ready_o !== 1'b0) || (swap_done_o !== 1'b0)) begin n_fail++; $display("FAIL swap_drain: got req=%0b rdy=%0b done=%0b want 1 0 0", mem_req_o, line_ready_o, swap_done_o); end
        tick();
        mem_ack_i = 1'b0;
        line_x_i = 10'd0; line_y_i = 9'd0; line_color_i = 24'hC0FFEE;
        #1;
        n_checks++; if ((swap_done_o !== 1'b1) || (front_sel_o !== 1'b1) || (mem_req_o !== 1'b0) || (line_ready_o !== 1'b0)) begin n_fail++; $display("FAIL swap_cycle: got done=%0b front=%0b req=%0b rdy=%0b want 1 1 0 0", swap_done_o, front_sel_o, mem_req_o, line_ready_o); end
        tick();
        #1;
        n_checks++; if ((swap_done_o !== 1'b0) || (line_ready_o !== 1'b1)) begin n_fail++; $display("FAIL swap_after: got done=%0b rdy=%0b want 0 1", swap_done_o, line_ready_o); end
        tick();
        line_valid_i = 1'b0;
        mem_ack_i = 1'b1;
        #1;
        n_checks++; if ((mem_req_o !== 1'b1) || (mem_addr_o !== 20'h00000) || (mem_data_o !== 24'hC0FFEE)) begin n_fail++; $display("FAIL swap_new_buffer: got req=%0b %h/%h want 1 00000/c0ffee", mem_req_o, mem_addr_o, mem_data_o); end
        tick();
        mem_ack_i = 1'b0;
    endtask

    task automatic test_double_swap;
        int dones;
        int done_cycle;
        dones = 0;
        done_cycle = -1;
        line_valid_i = 1'b1; line_x_i = 10'd1; line_y_i = 9'd1; line_color_i = 24'h0F0F0F;
        tick();
        line_valid_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            swap_req_i = (c == 0) || (c == 2);
            mem_ack_i  = (c == 3);
            #1;
            if (c == 0) begin
                n_checks++; if (mem_addr_o !== 20'h00281) begin n_fail++; $display("FAIL dswap_addr: got %h want 00281", mem_addr_o); end
            end
            if (swap_done_o === 1'b1) begin dones++; done_cycle = c; end
            tick();
        end
        swap_req_i = 1'b0;
        mem_ack_i = 1'b0;
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL dswap_count: got %0d want 1", dones); end
        n_checks++; if (done_cycle !== 4) begin n_fail++; $display("FAIL dswap_cycle: got %0d want 4", done_cycle); end
        n_checks++; if ((front_sel_o !== 1'b0) || (idle_o !== 1'b1)) begin n_fail++; $display("FAIL dswap_final: got front=%0b idle=%0b want 0 1", front_sel_o, idle_o); end
    endtask

    task automatic test_reset_mid_write;
        swap_req_i = 1'b1;
        tick();
        swap_req_i = 1'b0;
        #1;
        n_checks++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL idle_swap_pending: got %0b want 0", idle_o); end
        tick();
        n_checks++; if ((swap_done_o !== 1'b1) || (front_sel_o !== 1'b1)) begin n_fail++; $display("FAIL idle_swap: got done=%0b front=%0b want 1 1", swap_done_o, front_sel_o); end
        tick();
        line_valid_i = 1'b1; line_x_i = 10'd3; line_y_i = 9'd0; line_color_i = 24'h777777;
        tick();
        line_valid_i = 1'b0;
        #1;
        n_checks++; if ((mem_req_o !== 1'b1) || (mem_addr_o !== 20'h00003)) begin n_fail++; $display("FAIL rst_pre: got req=%0b addr=%h want 1 00003", mem_req_o, mem_addr_o); end
        #2;
        n_rst = 1'b0;
        #1;
        n_checks++; if ((mem_req_o !== 1'b0) || (front_sel_o !== 1'b0) || (clip_count_o !== 16'd0)) begin n_fail++; $display("FAIL rst_async: got req=%0b front=%0b cnt=%0d want 0 0 0", mem_req_o, front_sel_o, clip_count_o); end
        repeat (2) tick();
        n_rst = 1'b1;
        line_valid_i = 1'b1; line_x_i = 10'd7; line_y_i = 9'd3; line_color_i = 24'hABCDEF;
        fill_valid_i = 1'b1; fill_x_i = 10'd8; fill_y_i = 9'd3; fill_color_i = 24'h654321;
        #1;
        n_checks++; if ({line_ready_o, fill_ready_o} !== 2'b10) begin n_fail++; $display("FAIL rst_grant: got %b want 10", {line_ready_o, fill_ready_o}); end
        tick();
        line_valid_i = 1'b0;
        fill_valid_i = 1'b0;
        mem_ack_i = 1'b1;
        #1;
        n_checks++; if ((mem_req_o !== 1'b1) || (mem_addr_o !== 20'h80787) || (mem_data_o !== 24'hABCDEF)) begin n_fail++; $display("FAIL rst_write: got req=%0b %h/%h want 1 80787/abcdef", mem_req_o, mem_addr_o, mem_data_o); end
        tick();
        mem_ack_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        n_rst = 1'b0;
        line_valid_i = 1'b0; line_x_i = 10'd0; line_y_i = 9'd0; line_color_i = 24'd0;
        fill_valid_i = 1'b0; fill_x_i = 10'd0; fill_y_i = 9'd0; fill_color_i = 24'd0;
        swap_req_i = 1'b0;
        mem_ack_i = 1'b0;
        test_reset();
        test_back_to_back();
        test_single_write();
        test_clip();
        test_swap_drain();
        test_double_swap();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
